// File: rtl/game_pkg.sv
// Shared game definitions: default widths, sequence-checker state encoding and keypad codes.
package game_pkg;

    localparam int unsigned DEF_KEY_W          = 4;
    localparam int unsigned DEF_MAX_LEN        = 8;
    localparam int unsigned DEF_CNT_W          = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PASS    = 2'd2,
        ST_FAIL    = 2'd3
    } seq_state_e;

    // Key codes as emitted by the keypad decoder (low nibble)
    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

endpackage

// File: rtl/key_edge_detect.sv
// Registered rising-edge detector for the keypad ready strobe: one pulse per press,
// however long the strobe is held.
module key_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/key_sequence_checker.sv
// Checks keypad presses against the round's target digit sequence and reports pass/fail.
// Optional per-digit idle timeout: define KEY_SEQ_TIMEOUT_EN (adds TIMEOUT_CYCLES and timed_out).
module key_sequence_checker
    import game_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned KEY_W   = DEF_KEY_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
`ifdef KEY_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         seq_len,
    input  logic [MAX_LEN*KEY_W-1:0] target_seq,
    input  logic [KEY_W-1:0]         key_code,
    input  logic                     key_ready,
    output logic                     busy,
    output logic [CNT_W-1:0]         digit_count,
    output logic [KEY_W-1:0]         last_key,
    output logic                     done,
    output logic                     pass,
    output logic                     fail
`ifdef KEY_SEQ_TIMEOUT_EN
    , output logic                   timed_out
`endif
);

    seq_state_e               state_q, state_d;
    logic [CNT_W-1:0]         len_q, len_d;
    logic [MAX_LEN*KEY_W-1:0] tgt_q, tgt_d;
    logic                     bad_q, bad_d;
    logic [KEY_W-1:0]         key_code_q;
    logic                     key_evt;
    logic                     len_ok;
    logic [KEY_W-1:0]         exp_key;

    logic                     busy_d, done_d, pass_d, fail_d;
    logic [CNT_W-1:0]         cnt_d;
    logic [KEY_W-1:0]         last_d;

`ifdef KEY_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_q, to_d;
    logic            tout_d;
`endif

    key_edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst),
        .level (key_ready),
        .pulse (key_evt)
    );

    // Code captured alongside the edge so the pulse compares the code present at the press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_code_q <= '0;
        else      key_code_q <= key_code;
    end

    assign len_ok  = (seq_len != '0) && (32'(seq_len) <= MAX_LEN);
    assign exp_key = KEY_W'(tgt_q >> (32'(digit_count) * KEY_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            tgt_q       <= '0;
            bad_q       <= 1'b0;
            busy        <= 1'b0;
            digit_count <= '0;
            last_key    <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
`ifdef KEY_SEQ_TIMEOUT_EN
            to_q        <= '0;
            timed_out   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            tgt_q       <= tgt_d;
            bad_q       <= bad_d;
            busy        <= busy_d;
            digit_count <= cnt_d;
            last_key    <= last_d;
            done        <= done_d;
            pass        <= pass_d;
            fail        <= fail_d;
`ifdef KEY_SEQ_TIMEOUT_EN
            to_q        <= to_d;
            timed_out   <= tout_d;
`endif
        end
    end

    // Next state and next registered outputs; start overrides everything, including a key event
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        tgt_d   = tgt_q;
        bad_d   = 1'b0;
        cnt_d   = digit_count;
        last_d  = last_key;
        done_d  = 1'b0;
        pass_d  = pass;
        fail_d  = fail;
`ifdef KEY_SEQ_TIMEOUT_EN
        to_d    = '0;
        tout_d  = timed_out;
`endif

        if (start) begin
            len_d  = seq_len;
            tgt_d  = target_seq;
            cnt_d  = '0;
            pass_d = 1'b0;
            fail_d = 1'b0;
`ifdef KEY_SEQ_TIMEOUT_EN
            tout_d = 1'b0;
`endif
            // A bad length waits one cycle in IDLE, then fails like any other round
            if (len_ok) begin
                state_d = ST_COLLECT;
            end else begin
                state_d = ST_IDLE;
                bad_d   = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bad_q) begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (key_evt) begin
                        last_d = key_code_q;
                        if (key_code_q == exp_key) begin
                            cnt_d = digit_count + CNT_W'(1);
                            if (cnt_d == len_q) begin
                                state_d = ST_PASS;
                                pass_d  = 1'b1;
                                done_d  = 1'b1;
                            end
                        end else begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                            done_d  = 1'b1;
                        end
                    end
`ifdef KEY_SEQ_TIMEOUT_EN
                    else if (to_q == TO_LAST) begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                        done_d  = 1'b1;
                        tout_d  = 1'b1;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_COLLECT);
    end

endmodule

// File: tb/tb_key_sequence_checker.sv
// Directed bench for key_sequence_checker: spec-level round model checked every cycle,
// plus hand-computed expectations. Define KEY_SEQ_TIMEOUT_EN to exercise the timeout.
module tb_key_sequence_checker;
    import game_pkg::*;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned KEY_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TO      = 20;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     start = 1'b0;
    logic [CNT_W-1:0]         seq_len = '0;
    logic [MAX_LEN*KEY_W-1:0] target_seq = '0;
    logic [KEY_W-1:0]         key_code = '0;
    logic                     key_ready = 1'b0;
    logic                     busy, done, pass, fail;
    logic [CNT_W-1:0]         digit_count;
    logic [KEY_W-1:0]         last_key;
`ifdef KEY_SEQ_TIMEOUT_EN
    logic                     timed_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    key_sequence_checker #(
        .MAX_LEN (MAX_LEN),
        .KEY_W   (KEY_W),
        .CNT_W   (CNT_W)
`ifdef KEY_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seq_len     (seq_len),
        .target_seq  (target_seq),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .busy        (busy),
        .digit_count (digit_count),
        .last_key    (last_key),
        .done        (done),
        .pass        (pass),
        .fail        (fail)
`ifdef KEY_SEQ_TIMEOUT_EN
        , .timed_out (timed_out)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round model: what a player's presses must produce, tracked as round variables
    int m_busy, m_cnt, m_last, m_done, m_pass, m_fail;
    int m_round, m_bad, m_len, m_timer;
    int m_tgt[MAX_LEN];
    int kr_prev, ev_pipe, code_pipe;
`ifdef KEY_SEQ_TIMEOUT_EN
    int m_to;
`endif

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 0; m_cnt = 0; m_last = 0; m_done = 0; m_pass = 0; m_fail = 0;
            m_round = 0; m_bad = 0; m_len = 0; m_timer = 0;
            kr_prev = 0; ev_pipe = 0; code_pipe = 0;
            foreach (m_tgt[i]) m_tgt[i] = 0;
`ifdef KEY_SEQ_TIMEOUT_EN
            m_to = 0;
`endif
        end else begin : step
            int ev, code;
            ev        = ev_pipe;
            code      = code_pipe;
            ev_pipe   = (key_ready && kr_prev == 0) ? 1 : 0;
            kr_prev   = int'(key_ready);
            code_pipe = int'(key_code);
            m_done    = 0;
            if (start) begin
                m_len = int'(seq_len);
                for (int i = 0; i < int'(MAX_LEN); i++) m_tgt[i] = int'(target_seq[i*KEY_W +: KEY_W]);
                m_cnt = 0; m_pass = 0; m_fail = 0; m_timer = 0;
`ifdef KEY_SEQ_TIMEOUT_EN
                m_to = 0;
`endif
                if (m_len == 0 || m_len > int'(MAX_LEN)) begin
                    m_round = 0; m_bad = 1;
                end else begin
                    m_round = 1; m_bad = 0;
                end
            end else if (m_bad != 0) begin
                m_bad = 0; m_fail = 1; m_done = 1;
            end else if (m_round != 0) begin
                if (ev != 0) begin
                    m_last  = code;
                    m_timer = 0;
                    if (code == m_tgt[m_cnt]) begin
                        m_cnt++;
                        if (m_cnt == m_len) begin m_round = 0; m_pass = 1; m_done = 1; end
                    end else begin
                        m_round = 0; m_fail = 1; m_done = 1;
                    end
                end
`ifdef KEY_SEQ_TIMEOUT_EN
                else if (m_timer == int'(TO) - 1) begin
                    m_round = 0; m_fail = 1; m_done = 1; m_to = 1;
                end else begin
                    m_timer++;
                end
`endif
            end
            m_busy = m_round;
        end
    end

    // Every-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("busy",        32'(busy),        32'(m_busy));
            chk("digit_count", 32'(digit_count), 32'(m_cnt));
            chk("last_key",    32'(last_key),    32'(m_last));
            chk("done",        32'(done),        32'(m_done));
            chk("pass",        32'(pass),        32'(m_pass));
            chk("fail",        32'(fail),        32'(m_fail));
`ifdef KEY_SEQ_TIMEOUT_EN
            chk("timed_out",   32'(timed_out),   32'(m_to));
`endif
            if (done) n_done++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int len, input logic [31:0] tgt);
        start      = 1'b1;
        seq_len    = CNT_W'(len);
        target_seq = tgt;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int gap);
        key_code  = code;
        key_ready = 1'b1;
        tick(hold);
        key_ready = 1'b0;
        tick(gap);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        tick(2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt",  32'(digit_count), 0);
        chk("rst_last", 32'(last_key), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_fail", 32'(fail), 0);
        rst = 1'b1;
        tick(2);

        // Correct sequence 1,5,9 with done latency check on the last key
        do_start(3, 32'h0000_0951);
        chk("t1_busy", 32'(busy), 1);
        press(KEY_1, 16, 4);
        press(KEY_5, 16, 4);
        d0 = n_done;
        key_code = KEY_9; key_ready = 1'b1;
        tick(1);
        chk("t1_lat_early", 32'(done), 0);
        tick(1);
        chk("t1_done", 32'(done), 1);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_fail", 32'(fail), 0);
        chk("t1_cnt",  32'(digit_count), 3);
        chk("t1_last", 32'(last_key), 9);
        tick(1);
        chk("t1_done_off", 32'(done), 0);
        tick(13);
        key_ready = 1'b0;
        tick(4);
        chk("t1_done_pulses", 32'(n_done - d0), 1);

        // Wrong second digit aborts; later presses ignored
        do_start(3, 32'h0000_0951);
        press(KEY_1, 16, 4);
        d0 = n_done;
        press(KEY_4, 16, 4);
        chk("t2_fail", 32'(fail), 1);
        chk("t2_pass", 32'(pass), 0);
        chk("t2_cnt",  32'(digit_count), 1);
        chk("t2_last", 32'(last_key), 4);
        chk("t2_done_pulses", 32'(n_done - d0), 1);
        press(KEY_9, 16, 4);
        chk("t2_last_hold", 32'(last_key), 4);
        chk("t2_cnt_hold",  32'(digit_count), 1);
        chk("t2_done_none", 32'(n_done - d0), 1);

        // Long strobe counts once
        do_start(2, 32'h0000_0011);
        key_code = KEY_1; key_ready = 1'b1;
        tick(50);
        chk("t3_cnt",  32'(digit_count), 1);
        chk("t3_busy", 32'(busy), 1);
        key_ready = 1'b0;
        tick(4);
        press(KEY_1, 8, 4);
        chk("t3_pass", 32'(pass), 1);
        chk("t3_cnt2", 32'(digit_count), 2);

        // Restart mid-round: no done for the abandoned round
        do_start(4, 32'h0000_5432);
        press(KEY_2, 6, 4);
        press(KEY_3, 6, 4);
        chk("t4_cnt_mid", 32'(digit_count), 2);
        d0 = n_done;
        do_start(2, 32'h0000_0070);
        chk("t4_cnt_clr", 32'(digit_count), 0);
        chk("t4_busy",    32'(busy), 1);
        chk("t4_no_done", 32'(n_done - d0), 0);
        press(KEY_0, 6, 4);
        press(KEY_7, 6, 4);
        chk("t4_pass", 32'(pass), 1);
        chk("t4_done_pulses", 32'(n_done - d0), 1);

        // Illegal lengths fail two cycles after start
        for (int k = 0; k < 2; k++) begin
            d0 = n_done;
            do_start((k == 0) ? 0 : 9, 32'h0000_0123);
            chk("t5_done_early", 32'(done), 0);
            chk("t5_fail_clr",   32'(fail), 0);
            tick(1);
            chk("t5_done", 32'(done), 1);
            chk("t5_fail", 32'(fail), 1);
            chk("t5_busy", 32'(busy), 0);
            tick(2);
            chk("t5_done_pulses", 32'(n_done - d0), 1);
        end

        // Asynchronous reset mid-round
        do_start(3, 32'h0000_0951);
        press(KEY_1, 8, 4);
        chk("t6_cnt_pre", 32'(digit_count), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_cnt",  32'(digit_count), 0);
        chk("t6_last", 32'(last_key), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_pass", 32'(pass), 0);
        chk("t6_fail", 32'(fail), 0);
        tick(2);
        rst = 1'b1;
        tick(2);

`ifdef KEY_SEQ_TIMEOUT_EN
        // Idle round times out after TO collect cycles
        do_start(2, 32'h0000_0021);
        tick(19);
        chk("t7_done_early", 32'(done), 0);
        chk("t7_busy",       32'(busy), 1);
        tick(1);
        chk("t7_done",      32'(done), 1);
        chk("t7_fail",      32'(fail), 1);
        chk("t7_timed_out", 32'(timed_out), 1);
        do_start(3, 32'h0000_0321);
        chk("t7_to_clr", 32'(timed_out), 0);
        press(KEY_1, 3, 7);
        press(KEY_2, 3, 7);
        press(KEY_3, 3, 7);
        chk("t7_pass",   32'(pass), 1);
        chk("t7_no_to",  32'(timed_out), 0);
`else
        // Without the timeout an idle round waits indefinitely
        do_start(2, 32'h0000_0021);
        tick(200);
        chk("t7_wait_busy", 32'(busy), 1);
        chk("t7_wait_fail", 32'(fail), 0);
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
